dmem_arbiter: RTL



---
 rtl/arb_pkg.sv | 22 ++
 rtl/owner_fifo.sv | 74 +++++++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// arb_pkg: shared types for the data-memory arbiter (requester IDs, request bundle).
// Rev 1.0
package arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W/8-1:0]   wmask;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/owner_fifo.sv
`default_nettype none
// owner_fifo: in-order FIFO of requester IDs for outstanding reads; push and pop may coincide.
// Rev 1.0
module owner_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output req_id_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  req_id_t          slot_q [DEPTH];
  req_id_t          slot_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Caller guarantees push only when not full and pop only when not empty.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      slot_d[wr_ptr_q] = push_id;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= REQ_CORE;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = slot_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: round-robin core/debug arbiter onto one pipelined data-memory port.
// Rev 1.0
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wd,
  input  logic [DATA_W/8-1:0] c_wmask,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wd,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wd,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_orphan
);

  import arb_pkg::*;

  logic    fifo_full, fifo_empty;
  logic    push, pop;
  req_id_t push_id, head;
  logic    c_elig, d_elig, c_win, d_win;
  req_id_t last_gnt_q, last_gnt_d;
  logic    err_orphan_q, err_orphan_d;

  // Fullness is judged on the registered count: a same-cycle pop does not free a slot.
  always_comb begin
    c_elig       = c_req & mem_ready & (c_we | ~fifo_full);
    d_elig       = d_req & mem_ready & (d_we | ~fifo_full);
    c_win        = c_elig & (~d_elig | (last_gnt_q == REQ_DBG));
    d_win        = d_elig & ~c_win;
    push         = (c_win & ~c_we) | (d_win & ~d_we);
    push_id      = d_win ? REQ_DBG : REQ_CORE;
    pop          = mem_rvalid & ~fifo_empty;
    err_orphan_d = err_orphan_q | (mem_rvalid & fifo_empty);
    last_gnt_d   = last_gnt_q;
    if (c_win) begin
      last_gnt_d = REQ_CORE;
    end else if (d_win) begin
      last_gnt_d = REQ_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q   <= REQ_DBG;
      err_orphan_q <= 1'b0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (push_id),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // Handshake outputs are forced low while reset is asserted.
  assign c_gnt     = rst_n & c_win;
  assign d_gnt     = rst_n & d_win;
  assign mem_req   = rst_n & (c_win | d_win);
  assign c_rvalid  = rst_n & pop & (head == REQ_CORE);
  assign d_rvalid  = rst_n & pop & (head == REQ_DBG);
  assign c_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_we    = d_win ? d_we    : c_we;
  assign mem_addr  = d_win ? d_addr  : c_addr;
  assign mem_wd    = d_win ? d_wd    : c_wd;
  assign mem_wmask = d_win ? d_wmask : c_wmask;

  assign err_orphan = err_orphan_q;

endmodule
`default_nettype wire
